// File: rtl/apb2lb.sv
// rtl/apb2lb.sv - APB slave bridging single transfers onto a local bus with response timeout
module apb2lb #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [STRB_W-1:0] pstrb,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [ADDR_W-1:0] lb_waddr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic [STRB_W-1:0] lb_wstrb,
    output logic              lb_wen,
    input  logic              lb_wready,
    output logic [ADDR_W-1:0] lb_raddr,
    output logic              lb_ren,
    input  logic [DATA_W-1:0] lb_rdata,
    input  logic              lb_rvalid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counter value at which an unanswered request is abandoned.
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state;
    logic [15:0] wait_cnt;

    // Single FSM: accepts an APB setup in IDLE, holds the local-bus request until a
    // response or timeout, then pulses pready for one cycle in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= 16'd0;
            prdata   <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            lb_waddr <= '0;
            lb_wdata <= '0;
            lb_wstrb <= '0;
            lb_wen   <= 1'b0;
            lb_raddr <= '0;
            lb_ren   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    // Only the setup phase starts a transfer; responses arriving here are stale.
                    if (psel && !penable) begin
                        wait_cnt <= 16'd0;
                        if (pwrite) begin
                            lb_waddr <= paddr;
                            lb_wdata <= pwdata;
                            lb_wstrb <= pstrb;
                            lb_wen   <= 1'b1;
                            state    <= WRITE;
                        end else begin
                            lb_raddr <= paddr;
                            lb_ren   <= 1'b1;
                            state    <= READ;
                        end
                    end
                end
                WRITE: begin
                    // A response on the timeout edge still counts as a normal completion.
                    if (lb_wready) begin
                        lb_wen  <= 1'b0;
                        pready  <= 1'b1;
                        pslverr <= 1'b0;
                        state   <= DONE;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        lb_wen  <= 1'b0;
                        pready  <= 1'b1;
                        pslverr <= 1'b1;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                READ: begin
                    if (lb_rvalid) begin
                        lb_ren  <= 1'b0;
                        prdata  <= lb_rdata;
                        pready  <= 1'b1;
                        pslverr <= 1'b0;
                        state   <= DONE;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        lb_ren  <= 1'b0;
                        prdata  <= '0;
                        pready  <= 1'b1;
                        pslverr <= 1'b1;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DONE: begin
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb2lb.sv
// tb/tb_apb2lb.sv - scoreboard bench for apb2lb with directed APB transfers
module tb_apb2lb;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = 4;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              psel = 1'b0;
    logic              penable = 1'b0;
    logic              pwrite = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;
    logic [DATA_W-1:0] pwdata = '0;
    logic [STRB_W-1:0] pstrb = '0;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
    logic [ADDR_W-1:0] lb_waddr;
    logic [DATA_W-1:0] lb_wdata;
    logic [STRB_W-1:0] lb_wstrb;
    logic              lb_wen;
    logic              lb_wready = 1'b0;
    logic [ADDR_W-1:0] lb_raddr;
    logic              lb_ren;
    logic [DATA_W-1:0] lb_rdata = '0;
    logic              lb_rvalid = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        slverr;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] model_prdata = '0;

    apb2lb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb),
        .lb_wen(lb_wen), .lb_wready(lb_wready),
        .lb_raddr(lb_raddr), .lb_ren(lb_ren),
        .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every pready pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (rst && pready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pready", 32'(pready), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("pslverr", 32'(pslverr), 32'(e.slverr));
                chk("prdata", prdata, e.rdata);
            end
        end
    end

    // One APB transfer; delay = edge after setup on which the response is sampled (0 = never).
    task automatic apb_xfer(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int delay, input logic [31:0] rresp,
                            input int exp_req);
        exp_t e;
        int   req_cycles;
        bit   done;
        e.slverr = (delay == 0);
        if (!wr) model_prdata = (delay == 0) ? 32'd0 : rresp;
        e.rdata = model_prdata;
        sb_q.push_back(e);

        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        lb_wready = 1'b0; lb_rvalid = 1'b0;
        @(posedge clk);
        req_cycles = 0;
        done = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            penable = 1'b1;
            if (pready) begin
                done = 1'b1;
                psel = 1'b0; penable = 1'b0; lb_wready = 1'b0; lb_rvalid = 1'b0;
            end else begin
                if (lb_wen || lb_ren) req_cycles++;
                lb_wready = wr && (k == delay);
                lb_rvalid = !wr && (k == delay);
                lb_rdata  = rresp;
            end
        end
        if (!done) begin
            chk("pready_timeout", 32'(done), 32'd1);
            psel = 1'b0; penable = 1'b0; lb_wready = 1'b0; lb_rvalid = 1'b0;
        end
        chk("req_cycles", 32'(req_cycles), 32'(exp_req));
        @(negedge clk);
        chk("pready_one_cycle", 32'(pready), 32'd0);
        chk("req_released", 32'({lb_wen, lb_ren}), 32'd0);
        if (wr) begin
            chk("lb_waddr", 32'(lb_waddr), 32'(addr));
            chk("lb_wdata", lb_wdata, data);
            chk("lb_wstrb", 32'(lb_wstrb), 32'(strb));
        end else begin
            chk("lb_raddr", 32'(lb_raddr), 32'(addr));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        chk("rst_req", 32'({lb_wen, lb_ren, pslverr}), 32'd0);
        chk("rst_waddr", 32'(lb_waddr), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        apb_xfer(1'b1, 16'h0000, 32'hdeadbeef, 4'hf, 1, 32'h0, 1);
        apb_xfer(1'b0, 16'h0004, 32'h0, 4'h0, 3, 32'h00ffff00, 3);
        apb_xfer(1'b1, 16'h0008, 32'h66778899, 4'b0110, 2, 32'h0, 2);
        apb_xfer(1'b0, 16'h0010, 32'h0, 4'h0, 0, 32'hffffffff, TIMEOUT + 1);

        // Late read response in IDLE must not disturb anything.
        lb_rvalid = 1'b1; lb_rdata = 32'h0000abcd;
        @(negedge clk);
        lb_rvalid = 1'b0;
        @(negedge clk);
        chk("late_prdata", prdata, 32'd0);
        chk("late_req", 32'({lb_wen, lb_ren, pready}), 32'd0);

        apb_xfer(1'b0, 16'h0014, 32'h0, 4'h0, TIMEOUT + 1, 32'h12345678, TIMEOUT + 1);
        apb_xfer(1'b1, 16'h0018, 32'haaaa5555, 4'h3, 0, 32'h0, TIMEOUT + 1);
        apb_xfer(1'b0, 16'h000c, 32'h0, 4'hf, 2, 32'hcafef00d, 2);
        chk("read_keeps_wstrb", 32'(lb_wstrb), 32'h3);
        chk("read_keeps_waddr", 32'(lb_waddr), 32'h18);

        // Reset while a write request is outstanding.
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0020; pwdata = 32'h11112222; pstrb = 4'hf;
        lb_wready = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        chk("pre_rst_wen", 32'(lb_wen), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_wen", 32'(lb_wen), 32'd0);
        chk("async_rst_waddr", 32'(lb_waddr), 32'd0);
        chk("async_rst_prdata", prdata, 32'd0);
        model_prdata = 32'd0;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_pready", 32'(pready), 32'd0);

        apb_xfer(1'b1, 16'h0024, 32'h0badf00d, 4'hf, 1, 32'h0, 1);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
